// File: rtl/fm_op_sched_if.sv
// Host/datapath-facing signal bundle of the FM operator sequencer.
interface fm_op_sched_if;
    logic       sample_tick;
    logic       reset_req;
    logic [5:0] reset_op;
    logic       am_dep;
    logic [5:0] op_sel;
    logic       next;
    logic       op_reset;
    logic [5:0] am_val;
    logic       busy;
    logic       sample_done;
    logic       init_done;
    logic       overrun;

    modport master (
        output sample_tick, reset_req, reset_op, am_dep,
        input  op_sel, next, op_reset, am_val, busy, sample_done, init_done, overrun
    );

    modport slave (
        input  sample_tick, reset_req, reset_op, am_dep,
        output op_sel, next, op_reset, am_val, busy, sample_done, init_done, overrun
    );
endinterface

// File: rtl/fm_op_sched.sv
// Per-sample operator slot sequencer: slot walk, state write strobe, per-op reset
// servicing, one-time init sweep and the shared tremolo (AM) triangle value.
module fm_op_sched #(
    parameter int unsigned NUM_OPS     = 36,
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned AM_DIV      = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    fm_op_sched_if.slave  bus
);
    localparam int unsigned OP_W    = 6;
    localparam int unsigned AM_W    = 6;
    localparam int unsigned POS_W   = 8;
    localparam int unsigned POS_MAX = 207;
    localparam int unsigned TRI_TOP = 104;
    localparam int unsigned STEP_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned DIV_W   = (AM_DIV > 1) ? $clog2(AM_DIV) : 1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q;
    logic [OP_W-1:0]    op_q;
    logic [NUM_OPS-1:0] pending_q, pending_d;
    logic               slot_rst_q;
    logic [POS_W-1:0]   pos_q;
    logic [DIV_W-1:0]   div_q;
    logic [AM_W-1:0]    am_q;
    logic               done_q, init_done_q, overrun_q;

    logic               sweep_c, last_step_c, last_slot_c, sweep_end_c;
    logic               slot_start_c, req_hit_c, slot_hit_c, div_wrap_c;
    logic [POS_W-1:0]   pos_d, tri_c;
    logic [AM_W-1:0]    am_d;

    assign sweep_c      = (state_q != ST_IDLE);
    assign last_step_c  = (step_q == STEP_W'(STEP_CYCLES - 1));
    assign last_slot_c  = last_step_c && (op_q == OP_W'(NUM_OPS - 1));
    assign sweep_end_c  = (state_q == ST_RUN) && last_slot_c;
    assign slot_start_c = (state_q == ST_RUN) && (step_q == '0);
    assign req_hit_c    = bus.reset_req && (bus.reset_op == op_q);
    // A request landing on the slot-start cycle is serviced in this same slot.
    assign slot_hit_c   = (step_q == '0) ? (pending_q[op_q] | req_hit_c) : slot_rst_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (last_slot_c)     state_d = ST_IDLE;
            ST_IDLE: if (bus.sample_tick) state_d = ST_RUN;
            ST_RUN:  if (last_slot_c)     state_d = ST_IDLE;
            default:                      state_d = ST_INIT;
        endcase
    end

    // Slot walk: step within slot, operator index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            op_q   <= '0;
        end else if (!sweep_c) begin
            step_q <= '0;
            op_q   <= '0;
        end else if (last_step_c) begin
            step_q <= '0;
            op_q   <= (op_q == OP_W'(NUM_OPS - 1)) ? '0 : op_q + OP_W'(1);
        end else begin
            step_q <= step_q + STEP_W'(1);
        end
    end

    // Pending reset requests; a new set beats the slot-start clear
    always_comb begin
        pending_d = pending_q;
        if (slot_start_c) pending_d[op_q] = 1'b0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (bus.reset_req && (bus.reset_op == OP_W'(i))) pending_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            slot_rst_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (slot_start_c) slot_rst_q <= slot_hit_c;
        end
    end

    // Tremolo triangle: position advances every AM_DIV completed samples
    always_comb begin
        div_wrap_c = (div_q == DIV_W'(AM_DIV - 1));
        pos_d      = pos_q;
        if (div_wrap_c) pos_d = (pos_q == POS_W'(POS_MAX)) ? '0 : pos_q + POS_W'(1);
        tri_c      = (pos_d < POS_W'(TRI_TOP)) ? pos_d : POS_W'(POS_MAX) - pos_d;
        am_d       = bus.am_dep ? AM_W'(tri_c >> 1) : AM_W'(tri_c >> 3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            pos_q <= '0;
            am_q  <= '0;
        end else if (sweep_end_c) begin
            div_q <= div_wrap_c ? '0 : div_q + DIV_W'(1);
            pos_q <= pos_d;
            am_q  <= am_d;
        end
    end

    // Status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q      <= sweep_end_c;
            init_done_q <= init_done_q | ((state_q == ST_INIT) && last_slot_c);
            overrun_q   <= overrun_q | (bus.sample_tick && sweep_c && !sweep_end_c);
        end
    end

    assign bus.op_sel      = op_q;
    assign bus.next        = sweep_c && last_step_c;
    assign bus.op_reset    = (state_q == ST_INIT) || ((state_q == ST_RUN) && slot_hit_c);
    assign bus.am_val      = am_q;
    assign bus.busy        = sweep_c;
    assign bus.sample_done = done_q;
    assign bus.init_done   = init_done_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_fm_op_sched.sv
// Scoreboard bench for fm_op_sched: driver queues per-sweep expectations,
// a monitor accumulates each sweep and checks it at sample_done / init_done.
module tb_fm_op_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    fm_op_sched_if bus ();

    fm_op_sched #(.NUM_OPS(36), .STEP_CYCLES(4), .AM_DIV(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          nexts;
        logic [63:0] mask;
        int          rst_cyc;
        int          first_lat;
        int          done_lat;
        logic [5:0]  am;
        logic        ovr;
    } exp_t;

    exp_t sb_q[$];
    int   pos_m = 0;
    logic ovr_m = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [5:0] am_of(input int p, input logic dep);
        int t;
        t = (p < 104) ? p : 207 - p;
        return dep ? 6'(t >> 1) : 6'(t >> 3);
    endfunction

    task automatic push_init();
        exp_t e;
        pos_m = 0;
        ovr_m = 1'b0;
        e.nexts = 36; e.mask = (64'd1 << 36) - 64'd1; e.rst_cyc = 144;
        e.first_lat = 3; e.done_lat = 144; e.am = 6'd0; e.ovr = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic push_sample(input logic [63:0] m);
        exp_t e;
        pos_m = (pos_m + 1) % 208;
        e.nexts = 36; e.mask = m; e.rst_cyc = 4 * $countones(m);
        e.first_lat = 4; e.done_lat = 145; e.am = am_of(pos_m, bus.am_dep); e.ovr = ovr_m;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
    endtask

    task automatic req(input int op);
        @(posedge clk); #1 bus.reset_req = 1'b1; bus.reset_op = 6'(op);
        @(posedge clk); #1 bus.reset_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.sample_done) return;
        end
        total++;
        $display("FAIL %s: sample_done not seen within 400 cycles", name);
    endtask

    task automatic wait_init(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.init_done) return;
        end
        total++;
        $display("FAIL %s: init_done not seen within 400 cycles", name);
    endtask

    task automatic sample(input logic [63:0] m);
        push_sample(m);
        tick();
        wait_done("sample");
    endtask

    // Monitor: per-sweep accumulators
    int          nx, rc, first, last_nx, start, sd_early;
    logic [63:0] mk;
    bit          seq_bad;
    bit          prev_rst, prev_init;

    task automatic clear_acc();
        nx = 0; rc = 0; first = -1; last_nx = 0; mk = '0; seq_bad = 1'b0; sd_early = 0;
    endtask

    task automatic finish_sweep(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            $display("FAIL %s: unexpected sweep completion at cycle %0d", name, cyc);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_nexts"},     nx,              e.nexts);
            chk({name, "_rst_mask"},  mk,              e.mask);
            chk({name, "_rst_cyc"},   rc,              e.rst_cyc);
            chk({name, "_first_lat"}, first,           e.first_lat);
            chk({name, "_done_lat"},  cyc - start,     e.done_lat);
            chk({name, "_end_gap"},   cyc - last_nx,   1);
            chk({name, "_am_val"},    bus.am_val,      e.am);
            chk({name, "_overrun"},   bus.overrun,     e.ovr);
            chk({name, "_busy"},      bus.busy,        0);
            chk({name, "_seq_err"},   seq_bad,         0);
            chk({name, "_early_sd"},  sd_early,        0);
        end
        clear_acc();
    endtask

    initial begin
        clear_acc();
        prev_rst = 1'b0;
        prev_init = 1'b0;
        start = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                clear_acc();
                prev_rst = 1'b0;
                prev_init = 1'b0;
            end else begin
                if (!prev_rst) start = cyc;
                prev_rst = 1'b1;
                if (bus.sample_tick && !bus.busy) start = cyc;
                if (bus.sample_done && !bus.init_done) sd_early++;
                if (bus.init_done && !prev_init) finish_sweep("init");
                else if (bus.sample_done) finish_sweep("sample");
                prev_init = bus.init_done;
                if (bus.busy) begin
                    if (bus.next) begin
                        if (nx == 0) first = cyc - start;
                        else if (cyc - last_nx != 4) seq_bad = 1'b1;
                        if (bus.op_sel != 6'(nx)) seq_bad = 1'b1;
                        last_nx = cyc;
                        nx++;
                    end
                    if (bus.op_reset) begin
                        rc++;
                        mk = mk | (64'd1 << bus.op_sel);
                    end
                end else if (bus.op_reset || bus.next) begin
                    seq_bad = 1'b1;
                end
            end
        end
    end

    // Driver
    initial begin
        bus.sample_tick = 1'b0;
        bus.reset_req   = 1'b0;
        bus.reset_op    = 6'd0;
        bus.am_dep      = 1'b1;

        // Power-up init sweep
        repeat (3) @(posedge clk);
        chk("reset_busy",      bus.busy,      1);
        chk("reset_op_reset",  bus.op_reset,  1);
        chk("reset_am_val",    bus.am_val,    0);
        chk("reset_init_done", bus.init_done, 0);
        push_init();
        #1 rst_n = 1'b1;
        wait_init("init");

        // Plain sample
        sample(64'd0);

        // Idle request for op 5, then a clean sample
        req(5);
        sample(64'd1 << 5);
        sample(64'd0);

        // op 7 on its slot-start cycle, op 10 mid-slot
        push_sample(64'd1 << 7);
        tick();
        repeat (27) @(posedge clk);
        req(7);
        repeat (12) @(posedge clk);
        req(10);
        wait_done("req_slot_start");
        sample((64'd1 << 7) | (64'd1 << 10));
        sample(64'd0);

        // Tick while busy and an out-of-range request
        ovr_m = 1'b1;
        push_sample(64'd0);
        tick();
        repeat (20) @(posedge clk);
        #1 bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
        req(40);
        wait_done("overrun");
        sample(64'd0);

        // Tremolo peak, shallow depth, wrap
        while (pos_m < 104) sample(64'd0);
        chk("am_peak_deep", bus.am_val, 51);
        bus.am_dep = 1'b0;
        sample(64'd0);
        chk("am_peak_shallow", bus.am_val, 12);
        bus.am_dep = 1'b1;
        while (pos_m != 0) sample(64'd0);
        chk("am_wrap", bus.am_val, 0);
        repeat (10) sample(64'd0);
        chk("am_pos10", bus.am_val, 5);

        // Reset mid-RUN restarts the init sweep
        req(3);
        tick();
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy",     bus.busy,     1);
        chk("midrst_am_val",   bus.am_val,   0);
        chk("midrst_overrun",  bus.overrun,  0);
        push_init();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init("reinit");
        sample(64'd0);

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
